// File: rtl/trivium_byte_ctrl.sv
// Byte-stream controller around a bit-serial Trivium keystream core.
// Optional accepted-byte counter enabled by defining TRIVIUM_BYTE_COUNT_EN.
module trivium_byte_ctrl #(
  parameter int WARMUP = 1155,
  parameter int CNT_W  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        core_rst,
  output logic        core_enable,
  input  logic        core_ks_bit,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] byte_count,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // out_valid/out_data hold until out_ready; in_ready never depends on in_valid.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CORE_RST = 3'd1,
    S_WARMUP   = 3'd2,
    S_GATHER   = 3'd3,
    S_READY    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] GATHER_LAST = CNT_W'(7);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_ks_byte;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             w_in_ready;
  logic             w_accept;

  // start wins over a same-cycle handshake by masking in_ready.
  assign w_in_ready = (r_state == S_READY) && (!r_out_valid || out_ready) && !start;
  assign w_accept   = in_valid && w_in_ready;
  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign dbg_state  = r_state;

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    core_rst    = 1'b1;
    core_enable = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        core_rst = 1'b0;
        busy     = 1'b0;
      end
      S_CORE_RST: begin
        core_rst  = 1'b0;
        w_next    = S_WARMUP;
        w_cnt_nxt = '0;
      end
      S_WARMUP: begin
        core_enable = 1'b1;
        if (r_cnt == WARMUP_LAST) begin
          w_next    = S_GATHER;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GATHER: begin
        core_enable = 1'b1;
        if (r_cnt == GATHER_LAST) begin
          w_next    = S_READY;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_READY: begin
        busy = 1'b0;
        if (w_accept) begin
          w_next    = S_GATHER;
          w_cnt_nxt = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (start) begin
      w_next    = S_CORE_RST;
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // First gathered bit ends up in bit 0 after eight right shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ks_byte <= 8'h00;
    end else if (start) begin
      r_ks_byte <= 8'h00;
    end else if (r_state == S_GATHER) begin
      r_ks_byte <= {core_ks_bit, r_ks_byte[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else if (start) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data ^ r_ks_byte;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef TRIVIUM_BYTE_COUNT_EN
  logic [15:0] r_byte_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_count <= 16'h0000;
    end else if (start) begin
      r_byte_count <= 16'h0000;
    end else if (w_accept && (r_byte_count != 16'hFFFF)) begin
      r_byte_count <= r_byte_count + 16'd1;
    end
  end

  assign byte_count = r_byte_count;
`else
  assign byte_count = 16'h0000;
`endif

endmodule

// File: tb/tb_trivium_byte_ctrl.sv
// Directed bench for trivium_byte_ctrl: a counting core model supplies a known
// keystream and a scoreboard queue checks every ciphertext byte that drains.
module tb_trivium_byte_ctrl;

  localparam int WARMUP = 1155;

  logic        clk;
  logic        rst;
  logic        start;
  logic        core_rst;
  logic        core_enable;
  logic        core_ks_bit;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic [15:0] byte_count;
  logic [2:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          bc_model = 0;
  int          ks_pos;
  logic [7:0]  exp_q[$];
  logic [7:0]  ks_tab[0:7];

  trivium_byte_ctrl #(.WARMUP(WARMUP), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .start(start),
    .core_rst(core_rst), .core_enable(core_enable), .core_ks_bit(core_ks_bit),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .byte_count(byte_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- keystream core model ----------------
  initial begin
    ks_tab[0] = 8'h0D; // bits 1,0,1,1,0,0,0,0 LSB first
    ks_tab[1] = 8'hA5;
    ks_tab[2] = 8'h3C;
    ks_tab[3] = 8'h81;
    ks_tab[4] = 8'hFF;
    ks_tab[5] = 8'h00;
    ks_tab[6] = 8'h00;
    ks_tab[7] = 8'h00;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst)              ks_pos <= 0;
    else if (!core_rst)    ks_pos <= 0;
    else if (core_enable)  ks_pos <= ks_pos + 1;
  end

  function automatic logic ks_bit_at(input int pos);
    int k;
    logic [7:0] b;
    if (pos < WARMUP) return 1'b0;
    k = pos - WARMUP;
    if (k >= 64) return 1'b0;
    b = ks_tab[k / 8];
    return b[k % 8];
  endfunction

  assign core_ks_bit = ks_bit_at(ks_pos);

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bc_expected();
`ifdef TRIVIUM_BYTE_COUNT_EN
    return 16'(bc_model);
`else
    return 16'h0000;
`endif
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got %0h, expected no output", out_data);
      end else begin
        chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bc_model = 0;
    @(negedge clk);
    chk("cr_core_rst", {31'h0, core_rst}, 32'h0);
    chk("cr_enable", {31'h0, core_enable}, 32'h0);
    chk("cr_out_valid", {31'h0, out_valid}, 32'h0);
    chk("cr_busy", {31'h0, busy}, 32'h1);
  endtask

  task automatic check_warmup(input string name);
    int n;
    int bad;
    n = 0;
    bad = 0;
    @(negedge clk);
    while (core_enable && n < 2000) begin
      if (!core_rst || in_ready || !busy) bad++;
      n++;
      @(negedge clk);
    end
    chk(name, n, WARMUP + 8);
    chk({name, "_ctrl"}, bad, 0);
    chk({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  task automatic send_byte(input logic [7:0] din, input logic [7:0] exp, input bit push);
    for (int i = 0; i < 3000 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
      return;
    end
    in_valid = 1'b1;
    in_data  = din;
    if (push) exp_q.push_back(exp);
    if (bc_model < 16'hFFFF) bc_model++;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", {31'h0, out_valid}, 32'h1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs",
          {3'h0, core_rst, core_enable, in_ready, out_valid, busy, out_data, byte_count}, 32'h0);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_outputs",
          {3'h0, core_rst, core_enable, in_ready, out_valid, busy, out_data, byte_count}, 32'h0);
      chk("idle_state", {29'h0, dbg_state}, 32'h0);
    end

    // Start and full warm-up plus first gather
    do_start();
    check_warmup("warmup_len");

    // Encrypt against the known keystream
    send_byte(8'hFF, 8'hF2, 1'b1);
    send_byte(8'h00, 8'hA5, 1'b1);
    send_byte(8'h5A, 8'h66, 1'b1);
    for (int i = 0; i < 3000 && !in_ready; i++) @(negedge clk);
    chk("byte_count_3", {16'h0, byte_count}, {16'h0, bc_expected()});

    // Backpressure: output must hold while out_ready is low
    @(posedge clk); #1 out_ready = 1'b0;
    send_byte(8'h7E, 8'hFF, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_data", {24'h0, out_data}, 32'hFF);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send_byte(8'h12, 8'hED, 1'b1);

    // Restart with a pending output, then again mid warm-up
    @(posedge clk); #1 out_ready = 1'b0;
    send_byte(8'h33, 8'h33, 1'b0);
    repeat (12) @(posedge clk);
    do_start();
    chk("bc_cleared", {16'h0, byte_count}, 32'h0);
    repeat (500) @(posedge clk);
    #1 out_ready = 1'b1;
    do_start();
    check_warmup("rewarm_len");
    send_byte(8'hFF, 8'hF2, 1'b1);

    // start beats a simultaneous handshake
    for (int i = 0; i < 3000 && !in_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    chk("prio_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    bc_model = 0;
    @(negedge clk);
    chk("prio_out_valid", {31'h0, out_valid}, 32'h0);
    chk("prio_core_rst", {31'h0, core_rst}, 32'h0);
    check_warmup("prio_warmup_len");
    send_byte(8'h00, 8'h0D, 1'b1);
    chk("byte_count_1", {16'h0, byte_count}, {16'h0, bc_expected()});

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
